// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
// Register-file geometry, requester count and the mod-3 pointer helper.
// No state; used by rr_pick3 and rf_write_arbiter.
package rf_write_arbiter_pkg;

    localparam int RF_DEPTH       = 8;
    localparam int RF_ADDR_W      = $clog2(RF_DEPTH);
    localparam int N_WR_REQ       = 3;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [1:0] LAST_RST = 2'd2;

    // Advance a requester index modulo 3.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rf_write_arbiter_rr_pick3.sv
// Round-robin selector over three requesters, searching last+1, last+2, last.
// Latency: combinational.
// Backpressure: en=0 suppresses every grant.
module rr_pick3
    import rf_write_arbiter_pkg::*;
(
    input  logic [N_WR_REQ-1:0] valid,
    input  logic [1:0]          last,
    input  logic                en,
    output logic [N_WR_REQ-1:0] gnt,
    output logic [1:0]          gnt_id
);

    logic [1:0] last_eff;
    logic [1:0] cand1;
    logic [1:0] cand2;

    always_comb begin
        // Pointer value 3 is unreachable; fold it onto 2 to stay safe.
        last_eff = (last == 2'd3) ? 2'd2 : last;
        cand1    = rr_next(last_eff);
        cand2    = rr_next(cand1);
        gnt      = '0;
        gnt_id   = '0;
        if (en) begin
            if (valid[cand1]) begin
                gnt[cand1] = 1'b1;
                gnt_id     = cand1;
            end else if (valid[cand2]) begin
                gnt[cand2] = 1'b1;
                gnt_id     = cand2;
            end else if (valid[last_eff]) begin
                gnt[last_eff] = 1'b1;
                gnt_id        = last_eff;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between three requesters, round-robin.
// Latency: accept at edge t drives rf_we/addr/data during cycle t+1.
// Backpressure: req_ready is the combinational grant, held low on stall or reset.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [N_WR_REQ-1:0]   req_valid,
    output logic [N_WR_REQ-1:0]   req_ready,
    input  logic [RF_ADDR_W-1:0]  req_addr0,
    input  logic [RF_ADDR_W-1:0]  req_addr1,
    input  logic [RF_ADDR_W-1:0]  req_addr2,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    input  logic [DATA_WIDTH-1:0] req_data2,
    output logic                  rf_we,
    output logic [RF_ADDR_W-1:0]  rf_wAddr,
    output logic [DATA_WIDTH-1:0] rf_wData,
    output logic [1:0]            rf_gnt_id
);

    logic [1:0]            last;
    logic                  pick_en;
    logic [N_WR_REQ-1:0]   gnt;
    logic [1:0]            gnt_id;
    logic                  xfer;
    logic [RF_ADDR_W-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Reset gates the grant so no requester sees an accept during reset.
    assign pick_en   = ~stall & ~rst;
    assign req_ready = gnt;
    assign xfer      = |gnt;

    rr_pick3 u_pick (
        .valid  (req_valid),
        .last   (last),
        .en     (pick_en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        sel_addr = req_addr2;
        sel_data = req_data2;
        case (gnt_id)
            2'd0: begin
                sel_addr = req_addr0;
                sel_data = req_data0;
            end
            2'd1: begin
                sel_addr = req_addr1;
                sel_data = req_data1;
            end
            default: begin
                sel_addr = req_addr2;
                sel_data = req_data2;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last      <= LAST_RST;
            rf_we     <= 1'b0;
            rf_wAddr  <= '0;
            rf_wData  <= '0;
            rf_gnt_id <= '0;
        end else begin
            rf_we <= xfer;
            if (xfer) begin
                last      <= gnt_id;
                rf_wAddr  <= sel_addr;
                rf_wData  <= sel_data;
                rf_gnt_id <= gnt_id;
            end
        end
    end

endmodule
